// File: rtl/fpu_mul_pipe.sv
// Three-stage pipelined IEEE-754 multiplier (unpack/classify, multiply/normalise, round/pack)
// with generic exponent/fraction widths, subnormal support, RNE rounding and valid/ready flow control.
module fpu_mul_pipe #(
  parameter int  EXP_W = 8,
  parameter int  MAN_W = 23,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] o,
  output logic [3:0]   flags
);

  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int SW   = $clog2(PW + 1);
  localparam int XW   = EW + SW + 1;
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_NAN  = 3'd4
  } fp_cls_e;

  function automatic fp_cls_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (e == {EXP_W{1'b0}}) begin
      classify = (f == {MAN_W{1'b0}}) ? CLS_ZERO : CLS_SUB;
    end else if (e == {EXP_W{1'b1}}) begin
      classify = (f == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
    end else begin
      classify = CLS_NORM;
    end
  endfunction

  // Highest set bit wins because the scan runs from LSB to MSB.
  function automatic logic [SW-1:0] lzc(input logic [PW-1:0] v);
    lzc = SW'(PW);
    for (int i = 0; i < PW; i++) begin
      if (v[i]) begin
        lzc = SW'(PW - 1 - i);
      end else begin
        lzc = lzc;
      end
    end
  endfunction

  logic en;

  logic [EXP_W-1:0] a_exp, b_exp;
  logic [MAN_W-1:0] a_frac, b_frac;
  fp_cls_e          a_cls, b_cls;
  logic             s1_sign, s1_special;
  logic [W-1:0]     s1_res;
  logic [3:0]       s1_flags;
  logic [MAN_W:0]   s1_man_a, s1_man_b;
  logic [EXP_W-1:0] s1_eff_a, s1_eff_b;
  logic [EW-1:0]    s1_exp;

  logic [PW-1:0]    prod, norm, shifted;
  logic [SW-1:0]    lz, sh;
  logic [XW-1:0]    exp_n, sh_full, exp_sub;
  logic             tiny, lost;

  logic             inc, inexact;
  logic [MAN_W+1:0] rnd;
  logic [XW-1:0]    exp_r;
  logic [MAN_W-1:0] frac_r;
  logic [W-1:0]     res3;
  logic [3:0]       fl3;

  logic             v1_d, v1_q, sign1_d, sign1_q, spec1_d, spec1_q;
  logic [W-1:0]     res1_d, res1_q;
  logic [3:0]       fl1_d, fl1_q;
  logic [MAN_W:0]   mana1_d, mana1_q, manb1_d, manb1_q;
  logic [EW-1:0]    exp1_d, exp1_q;

  logic             v2_d, v2_q, sign2_d, sign2_q, spec2_d, spec2_q;
  logic [W-1:0]     res2_d, res2_q;
  logic [3:0]       fl2_d, fl2_q;
  logic [MAN_W:0]   mant2_d, mant2_q;
  logic [XW-1:0]    exp2_d, exp2_q;
  logic             g2_d, g2_q, r2_d, r2_q, s2_d, s2_q, tiny2_d, tiny2_q;

  logic             out_valid_d, out_valid_q;
  logic [W-1:0]     o_d, o_q;
  logic [3:0]       flags_d, flags_q;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign o         = o_q;
  assign flags     = flags_q;

  assign a_exp  = a[W-2 -: EXP_W];
  assign b_exp  = b[W-2 -: EXP_W];
  assign a_frac = a[MAN_W-1:0];
  assign b_frac = b[MAN_W-1:0];

  // S1: classify operands, resolve special values, form mantissas and biased exponent sum
  always_comb begin
    a_cls      = classify(a_exp, a_frac);
    b_cls      = classify(b_exp, b_frac);
    s1_sign    = a[W-1] ^ b[W-1];
    s1_man_a   = {(a_exp != {EXP_W{1'b0}}), a_frac};
    s1_man_b   = {(b_exp != {EXP_W{1'b0}}), b_frac};
    s1_eff_a   = (a_exp == {EXP_W{1'b0}}) ? EXP_W'(1) : a_exp;
    s1_eff_b   = (b_exp == {EXP_W{1'b0}}) ? EXP_W'(1) : b_exp;
    s1_exp     = EW'(s1_eff_a) + EW'(s1_eff_b) - EW'(BIAS);
    s1_special = 1'b1;
    s1_res     = QNAN;
    s1_flags   = 4'b0000;
    if (a_cls == CLS_NAN || b_cls == CLS_NAN) begin
      s1_flags[3] = (a_cls == CLS_NAN && !a_frac[MAN_W-1]) || (b_cls == CLS_NAN && !b_frac[MAN_W-1]);
    end else if ((a_cls == CLS_INF && b_cls == CLS_ZERO) || (a_cls == CLS_ZERO && b_cls == CLS_INF)) begin
      s1_flags[3] = 1'b1;
    end else if (a_cls == CLS_INF || b_cls == CLS_INF) begin
      s1_res = {s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_cls == CLS_ZERO || b_cls == CLS_ZERO) begin
      s1_res = {s1_sign, {(W-1){1'b0}}};
    end else begin
      s1_special = 1'b0;
    end
  end

  // S2: full product, normalise to MSB, denormalise tiny results into guard/round/sticky
  always_comb begin
    prod    = PW'(mana1_q) * PW'(manb1_q);
    lz      = lzc(prod);
    norm    = prod << lz;
    exp_n   = {{(XW-EW){exp1_q[EW-1]}}, exp1_q} + XW'(1) - XW'(lz);
    tiny    = exp_n[XW-1] || (exp_n == {XW{1'b0}});
    sh_full = XW'(1) - exp_n;
    sh      = (sh_full > XW'(PW)) ? SW'(PW) : sh_full[SW-1:0];
    if (tiny) begin
      shifted = norm >> sh;
      lost    = |(norm & ~({PW{1'b1}} << sh));
      exp_sub = {XW{1'b0}};
    end else begin
      shifted = norm;
      lost    = 1'b0;
      exp_sub = exp_n;
    end
  end

  // S3: round to nearest even, detect overflow/underflow, pick special or arithmetic result
  always_comb begin
    inc     = g2_q & (r2_q | s2_q | mant2_q[0]);
    rnd     = {1'b0, mant2_q} + {{(MAN_W+1){1'b0}}, inc};
    inexact = g2_q | r2_q | s2_q;
    if (exp2_q == {XW{1'b0}}) begin
      exp_r = {{(XW-1){1'b0}}, rnd[MAN_W]};
    end else begin
      exp_r = exp2_q + {{(XW-1){1'b0}}, rnd[MAN_W+1]};
    end
    frac_r = rnd[MAN_W+1] ? {MAN_W{1'b0}} : rnd[MAN_W-1:0];
    if (spec2_q) begin
      res3 = res2_q;
      fl3  = fl2_q;
    end else if (exp_r >= XW'({EXP_W{1'b1}})) begin
      res3 = {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      fl3  = 4'b0101;
    end else begin
      res3 = {sign2_q, exp_r[EXP_W-1:0], frac_r};
      fl3  = {1'b0, 1'b0, tiny2_q & inexact, inexact};
    end
  end

  // Next-state for all pipeline registers: advance on enable, hold otherwise
  always_comb begin
    v1_d        = en ? in_valid   : v1_q;
    sign1_d     = en ? s1_sign    : sign1_q;
    spec1_d     = en ? s1_special : spec1_q;
    res1_d      = en ? s1_res     : res1_q;
    fl1_d       = en ? s1_flags   : fl1_q;
    mana1_d     = en ? s1_man_a   : mana1_q;
    manb1_d     = en ? s1_man_b   : manb1_q;
    exp1_d      = en ? s1_exp     : exp1_q;
    v2_d        = en ? v1_q       : v2_q;
    sign2_d     = en ? sign1_q    : sign2_q;
    spec2_d     = en ? spec1_q    : spec2_q;
    res2_d      = en ? res1_q     : res2_q;
    fl2_d       = en ? fl1_q      : fl2_q;
    mant2_d     = en ? shifted[PW-1 -: MAN_W+1] : mant2_q;
    exp2_d      = en ? exp_sub    : exp2_q;
    g2_d        = en ? shifted[MAN_W]   : g2_q;
    r2_d        = en ? shifted[MAN_W-1] : r2_q;
    s2_d        = en ? ((|shifted[MAN_W-2:0]) | lost) : s2_q;
    tiny2_d     = en ? tiny       : tiny2_q;
    out_valid_d = en ? v2_q       : out_valid_q;
    o_d         = (en && v2_q) ? res3 : o_q;
    flags_d     = (en && v2_q) ? fl3  : flags_q;
  end

  // Pipeline state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_d_unused_guard: begin end
      v1_q        <= 1'b0;
      sign1_q     <= 1'b0;
      spec1_q     <= 1'b0;
      res1_q      <= {W{1'b0}};
      fl1_q       <= 4'b0000;
      mana1_q     <= {(MAN_W+1){1'b0}};
      manb1_q     <= {(MAN_W+1){1'b0}};
      exp1_q      <= {EW{1'b0}};
      v2_q        <= 1'b0;
      sign2_q     <= 1'b0;
      spec2_q     <= 1'b0;
      res2_q      <= {W{1'b0}};
      fl2_q       <= 4'b0000;
      mant2_q     <= {(MAN_W+1){1'b0}};
      exp2_q      <= {XW{1'b0}};
      g2_q        <= 1'b0;
      r2_q        <= 1'b0;
      s2_q        <= 1'b0;
      tiny2_q     <= 1'b0;
      out_valid_q <= 1'b0;
      o_q         <= {W{1'b0}};
      flags_q     <= 4'b0000;
    end else begin
      v1_q        <= v1_d;
      sign1_q     <= sign1_d;
      spec1_q     <= spec1_d;
      res1_q      <= res1_d;
      fl1_q       <= fl1_d;
      mana1_q     <= mana1_d;
      manb1_q     <= manb1_d;
      exp1_q      <= exp1_d;
      v2_q        <= v2_d;
      sign2_q     <= sign2_d;
      spec2_q     <= spec2_d;
      res2_q      <= res2_d;
      fl2_q       <= fl2_d;
      mant2_q     <= mant2_d;
      exp2_q      <= exp2_d;
      g2_q        <= g2_d;
      r2_q        <= r2_d;
      s2_q        <= s2_d;
      tiny2_q     <= tiny2_d;
      out_valid_q <= out_valid_d;
      o_q         <= o_d;
      flags_q     <= flags_d;
    end
  end

endmodule

// File: tb/tb_fpu_mul_pipe.sv
// Directed self-checking bench for fpu_mul_pipe: binary32 default instance plus a binary16 instance.
module tb_fpu_mul_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, o32;
  logic [3:0]  flags32;
  logic        in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0] a16, b16, o16;
  logic [3:0]  flags16;

  fpu_mul_pipe u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32), .o(o32), .flags(flags32)
  );

  fpu_mul_pipe #(.EXP_W(5), .MAN_W(10)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .a(a16), .b(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .o(o16), .flags(flags16)
  );

  // Drives one binary32 operation and reports result and accept-to-valid latency (no checking).
  task automatic mul32(input logic [31:0] x, input logic [31:0] y,
                       output logic [31:0] res, output logic [3:0] fl, output int lat);
    a32 = x; b32 = y; in_valid32 = 1'b1; out_ready32 = 1'b1;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    lat = 1;
    while (!out_valid32 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o32; fl = flags32;
    @(posedge clk); #1;
  endtask

  task automatic mul16(input logic [15:0] x, input logic [15:0] y,
                       output logic [15:0] res, output logic [3:0] fl, output int lat);
    a16 = x; b16 = y; in_valid16 = 1'b1; out_ready16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 1;
    while (!out_valid16 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o16; fl = flags16;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid32 = 1'b0; out_ready32 = 1'b0; a32 = 32'h0; b32 = 32'h0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = 16'h0; b16 = 16'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid32); end
    n_checks++; if (o32 !== 32'h0) begin n_fail++; $display("FAIL reset_o: got %h expected 00000000", o32); end
    n_checks++; if (flags32 !== 4'h0) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", flags32); end
    n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready32); end
  endtask

  task automatic test_basic();
    logic [31:0] r; logic [3:0] f; int lat;
    mul32(32'h3FC00000, 32'h40000000, r, f, lat);
    n_checks++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL basic_o: got %h expected 40400000", r); end
    n_checks++; if (f !== 4'b0000) begin n_fail++; $display("FAIL basic_flags: got %b expected 0000", f); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_rounding();
    logic [31:0] r; logic [3:0] f; int lat;
    mul32(32'h03E2D22D, 32'h3CE374D4, r, f, lat);
    n_checks++; if (r !== 32'h014987E1) begin n_fail++; $display("FAIL round_rne_o: got %h expected 014987E1", r); end
    n_checks++; if (f !== 4'b0001) begin n_fail++; $display("FAIL round_rne_flags: got %b expected 0001", f); end
    mul32(32'h3F800001, 32'h3F800001, r, f, lat);
    n_checks++; if (r !== 32'h3F800002) begin n_fail++; $display("FAIL round_sticky_o: got %h expected 3F800002", r); end
    n_checks++; if (f !== 4'b0001) begin n_fail++; $display("FAIL round_sticky_flags: got %b expected 0001", f); end
  endtask

  task automatic test_specials();
    logic [31:0] va [6] = '{32'h00800000, 32'h7F000000, 32'h7F800000, 32'h80000000, 32'h7F800001, 32'hFF800000};
    logic [31:0] vb [6] = '{32'h3F000000, 32'h7F000000, 32'h00000000, 32'h3F800000, 32'h3F800000, 32'h40000000};
    logic [31:0] ve [6] = '{32'h00400000, 32'h7F800000, 32'h7FC00000, 32'h80000000, 32'h7FC00000, 32'hFF800000};
    logic [3:0]  vf [6] = '{4'b0000, 4'b0101, 4'b1000, 4'b0000, 4'b1000, 4'b0000};
    logic [31:0] r; logic [3:0] f; int lat;
    for (int i = 0; i < 6; i++) begin
      mul32(va[i], vb[i], r, f, lat);
      n_checks++; if (r !== ve[i]) begin n_fail++; $display("FAIL special_o[%0d]: got %h expected %h", i, r, ve[i]); end
      n_checks++; if (f !== vf[i]) begin n_fail++; $display("FAIL special_flags[%0d]: got %b expected %b", i, f, vf[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [3] = '{32'h3F800000, 32'h40400000, 32'hC0000000};
    logic [31:0] vb [3] = '{32'h40000000, 32'h40400000, 32'h40800000};
    logic [31:0] ve [3] = '{32'h40000000, 32'h41100000, 32'hC1000000};
    out_ready32 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_valid32 = (k < 3);
      a32 = (k < 3) ? va[k] : 32'h0;
      b32 = (k < 3) ? vb[k] : 32'h0;
      @(posedge clk); #1;
      if (k >= 2) begin
        n_checks++; if (out_valid32 !== 1'b1 || o32 !== ve[k-2]) begin
          n_fail++; $display("FAIL b2b_o[%0d]: got v=%b %h expected v=1 %h", k-2, out_valid32, o32, ve[k-2]);
        end
      end
    end
    in_valid32 = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got out_valid %b expected 0", out_valid32); end
  endtask

  task automatic test_stall();
    out_ready32 = 1'b0;
    in_valid32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40400000;
    @(posedge clk); #1;
    a32 = 32'h40000000; b32 = 32'h40000000;
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    @(posedge clk); #1;
    in_valid32 = 1'b1; a32 = 32'h40400000; b32 = 32'h40400000;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      n_checks++; if (out_valid32 !== 1'b1 || o32 !== 32'h40400000 || flags32 !== 4'b0000) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b %h %b expected v=1 40400000 0000", k, out_valid32, o32, flags32);
      end
      n_checks++; if (in_ready32 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d]: got %b expected 0", k, in_ready32); end
    end
    out_ready32 = 1'b1;
    #1;
    n_checks++; if (in_ready32 !== 1'b1) begin n_fail++; $display("FAIL stall_release_in_ready: got %b expected 1", in_ready32); end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
    n_checks++; if (out_valid32 !== 1'b1 || o32 !== 32'h40800000) begin
      n_fail++; $display("FAIL stall_second: got v=%b %h expected v=1 40800000", out_valid32, o32);
    end
    @(posedge clk); #1;
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL stall_bubble: got %b expected 0", out_valid32); end
    @(posedge clk); #1;
    n_checks++; if (out_valid32 !== 1'b1 || o32 !== 32'h41100000) begin
      n_fail++; $display("FAIL stall_held_input: got v=%b %h expected v=1 41100000", out_valid32, o32);
    end
    @(posedge clk); #1;
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL stall_no_dup: got %b expected 0", out_valid32); end
  endtask

  task automatic test_backpressure();
    logic [31:0] va [8] = '{32'h3F800000, 32'h40400000, 32'hC0000000, 32'h3FC00000,
                            32'h40A00000, 32'h7F800000, 32'h00000000, 32'h7F800001};
    logic [31:0] vb [8] = '{32'h40000000, 32'h40400000, 32'h40800000, 32'h3FC00000,
                            32'hBF000000, 32'hC0000000, 32'h41200000, 32'h3F800000};
    logic [31:0] ve [8] = '{32'h40000000, 32'h41100000, 32'hC1000000, 32'h40100000,
                            32'hC0200000, 32'hFF800000, 32'h00000000, 32'h7FC00000};
    logic [3:0]  vf [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
    int sent = 0, got = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [31:0] held = 32'h0;
    while (got < 8 && cyc < 400) begin
      out_ready32 = 1'($urandom_range(0, 1));
      in_valid32  = (sent < 8);
      a32 = (sent < 8) ? va[sent] : 32'h0;
      b32 = (sent < 8) ? vb[sent] : 32'h0;
      #1;
      n_checks++; if (in_ready32 !== (!out_valid32 || out_ready32)) begin
        n_fail++; $display("FAIL bp_in_ready: got %b expected %b", in_ready32, (!out_valid32 || out_ready32));
      end
      if (stalled) begin
        n_checks++; if (out_valid32 !== 1'b1 || o32 !== held) begin
          n_fail++; $display("FAIL bp_stable: got v=%b %h expected v=1 %h", out_valid32, o32, held);
        end
      end
      if (out_valid32 && out_ready32) begin
        n_checks++; if (o32 !== ve[got] || flags32 !== vf[got]) begin
          n_fail++; $display("FAIL bp_result[%0d]: got %h %b expected %h %b", got, o32, flags32, ve[got], vf[got]);
        end
        got++;
      end
      stalled = out_valid32 && !out_ready32;
      held = o32;
      if (in_valid32 && in_ready32) sent++;
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d results expected 8", got); end
    in_valid32 = 1'b0; out_ready32 = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL bp_extra: got out_valid %b expected 0", out_valid32); end
  endtask

  task automatic test_reset_midflight();
    out_ready32 = 1'b1;
    in_valid32 = 1'b1; a32 = 32'h3F800000; b32 = 32'h40000000;
    @(posedge clk); #1;
    a32 = 32'h40400000; b32 = 32'h40400000;
    @(posedge clk); #1;
    a32 = 32'h40A00000; b32 = 32'h3F000000;
    rst = 1'b1;
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL mid_pre_valid: got %b expected 0", out_valid32); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid32 = 1'b0;
    n_checks++; if (out_valid32 !== 1'b0 || o32 !== 32'h0 || flags32 !== 4'b0000) begin
      n_fail++; $display("FAIL mid_reset_state: got v=%b %h %b expected v=0 00000000 0000", out_valid32, o32, flags32);
    end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL mid_ghost[%0d]: got out_valid %b expected 0", k, out_valid32); end
    end
  endtask

  task automatic test_binary16();
    logic [15:0] r; logic [3:0] f; int lat;
    mul16(16'h3E00, 16'h4000, r, f, lat);
    n_checks++; if (r !== 16'h4200 || f !== 4'b0000) begin n_fail++; $display("FAIL h_basic: got %h %b expected 4200 0000", r, f); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL h_latency: got %0d expected 3", lat); end
    mul16(16'h0001, 16'h3800, r, f, lat);
    n_checks++; if (r !== 16'h0000) begin n_fail++; $display("FAIL h_tie_o: got %h expected 0000", r); end
    n_checks++; if (f !== 4'b0011) begin n_fail++; $display("FAIL h_tie_flags: got %b expected 0011", f); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_reset_midflight();
    test_binary16();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
